// File: rtl/fifo_drain.sv
// fifo_drain: pops an upstream FIFO into a two-entry skid buffer and presents the
// words downstream under valid/ready handshaking, with a saturating pop counter.
module fifo_drain #(
   parameter int FIFO_width = 64,
   parameter int CNT_width  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [FIFO_width-1:0] fifo_out,
   output logic                  fifo_consume,
   input  logic                  drain_en,
   output logic [FIFO_width-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_width-1:0]  pop_count,
   output logic                  idle
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_width-1:0] CNT_ONE = CNT_width'(1);
   localparam logic [CNT_width-1:0] CNT_MAX = '1;

   state_t                state, state_next;
   logic [FIFO_width-1:0] main_q, main_next;
   logic [FIFO_width-1:0] skid_q, skid_next;
   logic [CNT_width-1:0]  count_q;
   logic                  transfer;

   // Pop decision depends only on local occupancy, never on out_ready, so the
   // upstream pop strobe has no combinational path from the downstream side.
   assign fifo_consume = drain_en & ~fifo_empty & (state != TWO) & ~rst;
   assign out_valid    = (state != EMPTY);
   assign transfer     = out_valid & out_ready;
   assign out_data     = main_q;
   assign pop_count    = count_q;
   assign idle         = (state == EMPTY) & fifo_empty;

   // NOTE: every variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      main_next  = main_q;
      skid_next  = skid_q;
      case (state)
         EMPTY: begin
            if (fifo_consume) begin
               state_next = ONE;
               main_next  = fifo_out;
            end
         end
         ONE: begin
            if (fifo_consume && transfer) begin
               main_next = fifo_out;
            end else if (fifo_consume) begin
               state_next = TWO;
               skid_next  = fifo_out;
            end else if (transfer) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (transfer) begin
               state_next = ONE;
               main_next  = skid_q;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         count_q <= '0;
      end else begin
         state  <= state_next;
         main_q <= main_next;
         skid_q <= skid_next;
         if (fifo_consume && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a directed vector table, directed scenarios and a random
// run, all checked against a queue-based model of the two-word buffer.
module tb_fifo_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [63:0] fifo_out;
   logic        fifo_consume;
   logic        drain_en;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] pop_count;
   logic        idle;

   logic        sat_consume;
   logic [63:0] sat_data;
   logic        sat_valid;
   logic [3:0]  sat_count;
   logic        sat_idle;

   always #5 clk = ~clk;

   fifo_drain #(.FIFO_width(64), .CNT_width(16)) u_dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
      .fifo_consume(fifo_consume), .drain_en(drain_en), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .pop_count(pop_count), .idle(idle)
   );

   // Second instance with a narrow counter shares the stimulus to exercise saturation.
   fifo_drain #(.FIFO_width(64), .CNT_width(4)) u_sat (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
      .fifo_consume(sat_consume), .drain_en(drain_en), .out_data(sat_data),
      .out_valid(sat_valid), .out_ready(out_ready), .pop_count(sat_count), .idle(sat_idle)
   );

   typedef struct {
      logic        rst;
      logic        empty;
      logic [63:0] data;
      logic        en;
      logic        rdy;
      logic        exp_consume;
      logic        exp_valid;
      logic [63:0] exp_data;
      int          exp_cnt;
      logic        exp_idle;
   } vec_t;

   int tests = 0;
   int fails = 0;

   // Upstream FIFO contents and logs of what actually left it / left the DUT.
   logic [63:0] src[$];
   logic [63:0] popped_log[$];
   logic [63:0] dut_log[$];
   int          dut_xfers;

   // Reference model: the held words in order, popped total, last word on out_data.
   logic [63:0] held[$];
   int          cnt;
   logic [63:0] last;
   logic        force_empty;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle driven from the upstream FIFO model; entered just after a negedge.
   task automatic step();
      logic        exp_c;
      logic        exp_v;
      logic [63:0] head;
      logic [63:0] w;
      fifo_empty = force_empty || (src.size() == 0);
      head       = (src.size() > 0) ? src[0] : 64'd0;
      fifo_out   = head;
      #1;
      exp_c = drain_en && !fifo_empty && (held.size() < 2) && !rst;
      exp_v = (held.size() > 0);
      check("consume", {63'd0, fifo_consume}, {63'd0, exp_c});
      check("valid", {63'd0, out_valid}, {63'd0, exp_v});
      check("data", out_data, exp_v ? held[0] : last);
      check("count", {48'd0, pop_count}, (cnt > 65535) ? 64'd65535 : 64'(cnt));
      check("sat_count", {60'd0, sat_count}, (cnt > 15) ? 64'd15 : 64'(cnt));
      check("idle", {63'd0, idle}, {63'd0, (held.size() == 0) && fifo_empty});
      if (!rst && out_valid === 1'b1 && out_ready) begin
         dut_log.push_back(out_data);
         dut_xfers++;
      end
      if (fifo_consume === 1'b1 && src.size() > 0) begin
         popped_log.push_back(src.pop_front());
      end
      @(posedge clk);
      if (rst) begin
         held.delete();
         cnt  = 0;
         last = 64'd0;
      end else begin
         if (exp_v && out_ready) begin
            last = held.pop_front();
         end
         if (exp_c) begin
            held.push_back(head);
            cnt++;
         end
         if (held.size() > 0) last = held[0];
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      src.delete();
      popped_log.delete();
      dut_log.delete();
      dut_xfers = 0;
   endtask

   task automatic load(input int n, input logic [63:0] base);
      for (int i = 0; i < n; i++) src.push_back(base + 64'(i));
   endtask

   vec_t vecs[10];

   initial begin
      // Backpressure with 0xA,0xB,0xC, then an idle cycle and a reset cycle.
      vecs[0] = '{1'b0, 1'b0, 64'hA, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 64'hB, 1'b1, 1'b0, 1'b1, 1'b1, 64'hA, 1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA, 2, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1, 64'hA, 2, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 64'hC, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA, 2, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 64'hC, 1'b1, 1'b1, 1'b1, 1'b1, 64'hB, 2, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hC, 3, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hC, 3, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 64'hD, 1'b1, 1'b1, 1'b0, 1'b0, 64'hC, 3, 1'b0};
      vecs[9] = '{1'b0, 1'b0, 64'hD, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 0, 1'b0};

      rst = 1'b1; drain_en = 1'b0; out_ready = 1'b0;
      fifo_empty = 1'b1; fifo_out = 64'd0; force_empty = 1'b1;
      cnt = 0; last = 64'd0; dut_xfers = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         rst = vecs[i].rst; fifo_empty = vecs[i].empty; fifo_out = vecs[i].data;
         drain_en = vecs[i].en; out_ready = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d_consume", i), {63'd0, fifo_consume}, {63'd0, vecs[i].exp_consume});
         check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
         check($sformatf("vec%0d_count", i), {48'd0, pop_count}, 64'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_sat_count", i), {60'd0, sat_count}, 64'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_idle", i), {63'd0, idle}, {63'd0, vecs[i].exp_idle});
         @(posedge clk);
         @(negedge clk);
      end
      force_empty = 1'b0;

      // Streaming 0x1..0x8 at full rate.
      do_reset();
      load(8, 64'h1);
      drain_en = 1'b1; out_ready = 1'b1;
      repeat (9) step();
      #1;
      check("stream_xfers", 64'(dut_xfers), 64'd8);
      check("stream_count", {48'd0, pop_count}, 64'd8);
      check("stream_idle", {63'd0, idle}, 64'd1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("stream_word%0d", i), (i < dut_log.size()) ? dut_log[i] : 64'hX, 64'(i + 1));
      end

      // drain_en dropped while two words are held.
      do_reset();
      load(5, 64'h20);
      drain_en = 1'b1; out_ready = 1'b0;
      repeat (2) step();
      drain_en = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      check("toggle_xfers", 64'(dut_xfers), 64'd2);
      check("toggle_src_left", 64'(src.size()), 64'd3);
      drain_en = 1'b1;
      repeat (5) step();
      check("toggle_all_xfers", 64'(dut_xfers), 64'd5);
      check("toggle_last", (dut_log.size() == 5) ? dut_log[4] : 64'hX, 64'h24);

      // Counter saturation on the narrow instance.
      do_reset();
      load(20, 64'h100);
      drain_en = 1'b1; out_ready = 1'b1;
      repeat (21) step();
      #1;
      check("sat_value", {60'd0, sat_count}, 64'd15);
      check("sat_wide_value", {48'd0, pop_count}, 64'd20);
      check("sat_xfers", 64'(dut_xfers), 64'd20);

      // Reset while holding two words discards them.
      do_reset();
      load(4, 64'h11);
      drain_en = 1'b1; out_ready = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("mrst_valid", {63'd0, out_valid}, 64'd0);
      check("mrst_data", out_data, 64'd0);
      check("mrst_count", {48'd0, pop_count}, 64'd0);
      out_ready = 1'b1;
      repeat (4) step();
      check("mrst_first", (dut_log.size() > 0) ? dut_log[0] : 64'hX, 64'h13);
      check("mrst_xfers", 64'(dut_xfers), 64'd2);

      // Random upstream emptiness, backpressure and enable.
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         while (src.size() < 4) src.push_back({$urandom, $urandom});
         force_empty = ($urandom_range(0, 3) == 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         drain_en    = ($urandom_range(0, 7) != 0);
         step();
      end
      force_empty = 1'b0; drain_en = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      check("rand_len", 64'(dut_log.size()), 64'(popped_log.size()));
      for (int i = 0; i < dut_log.size() && i < popped_log.size(); i++) begin
         if (dut_log[i] !== popped_log[i]) begin
            check($sformatf("rand_word%0d", i), dut_log[i], popped_log[i]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
